// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the camera capture path and the display-side reader.
// Holds the pixel width, the capture FSM state encodings and the default
// frame geometry so both sides of the frame buffer agree on one layout.
package ov7670_capture_pkg;

   // Width of one stored RGB444 pixel {R[3:0], G[3:0], B[3:0]}.
   localparam int PIXEL_W = 12;

   // Default frame geometry; the reader uses the same values.
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int ADDR_W_DEF   = 19;

   // Capture FSM state encodings.
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_VS = 2'd1;
   localparam logic [1:0] ACTIVE  = 2'd2;

endpackage

// File: rtl/ov7670_capture_sig_edge.sv
// sig_edge: registered rise/fall detector for a single-bit level.
// The previous value is held in a flop; rise/fall are combinational
// comparisons of the current level against that flop, so they are valid
// in the same cycle the new level is present.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset (previous value cleared to 0)
//   sig   in  level to watch
//   rise  out sig is 1 now and was 0 last cycle
//   fall  out sig is 0 now and was 1 last cycle
module sig_edge (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset) prev <= 1'b0;
      else       prev <= sig;
   end

   assign rise = sig & ~prev;
   assign fall = ~sig & prev;

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 RGB444 byte-pair capture into a linear frame buffer.
// vsync/href/din are registered once; all decisions use those copies.
// Two bytes per pixel: the first gives red (low nibble), the second gives
// green (high nibble) and blue (low nibble).
//
// Output protocol: we is a one-cycle write strobe with no back-pressure;
// addr/dout are valid in the cycle we is high and hold their last values
// otherwise. frame_done is a one-cycle pulse; overflow is sticky.
//
// Ports:
//   clk, reset       pixel clock, synchronous active-high reset
//   arm              capture enable level; capture begins at a frame start
//   vsync, href, din camera bus
//   addr, dout, we   frame-buffer write port
//   frame_done       end of a fully captured frame
//   overflow         bytes beyond the active window were dropped
//   state            current FSM state (IDLE / WAIT_VS / ACTIVE)
module ov7670_capture
   import ov7670_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               arm,
   input  logic               vsync,
   input  logic               href,
   input  logic [7:0]         din,
   output logic [ADDR_W-1:0]  addr,
   output logic [PIXEL_W-1:0] dout,
   output logic               we,
   output logic               frame_done,
   output logic               overflow,
   output logic [1:0]         state
);

   localparam int COL_W  = $clog2(H_ACTIVE + 1);
   localparam int LINE_W = $clog2(V_ACTIVE + 1);
   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACTIVE);
   localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);

   logic              s_vs;
   logic              s_hr;
   logic [7:0]        s_d;
   logic              vs_rise;
   logic              vs_fall;
   logic              hr_rise;
   logic              hr_fall;
   logic [COL_W-1:0]  col;
   logic [LINE_W-1:0] line;
   logic [ADDR_W-1:0] row_base;
   logic              phase;
   logic [3:0]        hi;

   // Line starts are implied by the previous falling edge, so the rising
   // edge of href is not needed.
   logic unused_hr_rise;
   assign unused_hr_rise = hr_rise;

   always_ff @(posedge clk) begin
      if (reset) begin
         s_vs <= 1'b0;
         s_hr <= 1'b0;
         s_d  <= 8'd0;
      end else begin
         s_vs <= vsync;
         s_hr <= href;
         s_d  <= din;
      end
   end

   sig_edge u_vs_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (s_vs),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   sig_edge u_hr_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (s_hr),
      .rise  (hr_rise),
      .fall  (hr_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         col        <= '0;
         line       <= '0;
         row_base   <= '0;
         phase      <= 1'b0;
         hi         <= 4'd0;
         addr       <= '0;
         dout       <= '0;
         we         <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         we         <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               col      <= '0;
               line     <= '0;
               row_base <= '0;
               phase    <= 1'b0;
               if (arm) state <= WAIT_VS;
            end
            WAIT_VS: begin
               col      <= '0;
               line     <= '0;
               row_base <= '0;
               phase    <= 1'b0;
               if (!arm) begin
                  state <= IDLE;
               end else if (vs_fall) begin
                  state    <= ACTIVE;
                  overflow <= 1'b0;
               end
            end
            ACTIVE: begin
               // Dropping arm wins over everything, including a pixel that
               // completes this cycle; IDLE clears the counters next cycle.
               if (!arm) begin
                  state <= IDLE;
               end else begin
                  if (s_hr) begin
                     phase <= ~phase;
                     if (!phase) begin
                        hi <= s_d[3:0];
                     end else begin
                        if (col < COL_MAX && line < LINE_MAX) begin
                           we   <= 1'b1;
                           dout <= {hi, s_d};
                           addr <= row_base + ADDR_W'(col);
                        end else begin
                           overflow <= 1'b1;
                        end
                        if (col < COL_MAX) col <= col + 1'b1;
                     end
                  end
                  // End of line: any unpaired byte is simply forgotten.
                  // row_base only advances while a following line can still
                  // be written, so it never steps past the last row.
                  if (hr_fall) begin
                     col   <= '0;
                     phase <= 1'b0;
                     if (line < LINE_MAX) begin
                        line <= line + 1'b1;
                        if (line < LINE_MAX - 1'b1) row_base <= row_base + ROW_STEP;
                     end
                  end
                  if (vs_rise) begin
                     state      <= IDLE;
                     frame_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
